// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam int unsigned             DEF_NUM_WORDS = 512;
  localparam logic [ADDR_W-1:0]       DEF_BASE_ADDR = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Byte address of word idx relative to base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if;
  import loader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Packs four big-endian stream bytes into one 32-bit word.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte_c,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [1:0] byte_cnt;

  // Byte 3 of the current word is being accepted.
  assign last_byte_c = byte_en && (byte_cnt == 2'd3);

  // Shift register, byte counter and one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt  <= 2'd0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= last_byte_c;
      if (byte_en) begin
        word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned       NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(NUM_WORDS);

  state_t            state, next_state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  word_idx;
  logic [BYTE_W-1:0] csum;
  logic [ADDR_W-1:0] imem_addr;
  logic [CNT_W-1:0]  count_c;
  logic              xfer, accept_start, data_byte;
  logic              last_byte_c, word_done;
  logic [WORD_W-1:0] word;
  logic              busy_d, done_d, err_d, cpu_reset_d;

  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign accept_start = start && (state inside {IDLE, DONE, ERROR});
  assign data_byte    = xfer && (state == DATA);
  assign count_c      = {len[CNT_W-1:BYTE_W], bus.rx_data};

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept_start),
    .byte_en     (data_byte),
    .byte_in     (bus.rx_data),
    .last_byte_c (last_byte_c),
    .word_done   (word_done),
    .word        (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = LEN_HI;
      LEN_HI:            if (xfer) next_state = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if ({1'b0, count_c} > MAX_WORDS) next_state = ERROR;
          else if (count_c == '0)          next_state = CHECK;
          else                             next_state = DATA;
        end
      end
      DATA:  if (last_byte_c && (word_idx == len - CNT_W'(1))) next_state = CHECK;
      CHECK: if (xfer) next_state = (bus.rx_data == csum) ? DONE : ERROR;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: rx_ready from the current state, flags from the next state.
  always_comb begin
    bus.rx_ready = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    busy_d       = next_state inside {LEN_HI, LEN_LO, DATA, CHECK};
    done_d       = next_state == DONE;
    err_d        = next_state == ERROR;
    cpu_reset_d  = next_state != DONE;
  end

  // Registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cpu_reset <= cpu_reset_d;
    end
  end

  // Length, word index, running checksum and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      word_idx  <= '0;
      csum      <= '0;
      imem_addr <= '0;
    end else if (accept_start) begin
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else begin
      if (xfer && (state inside {LEN_HI, LEN_LO, DATA})) csum <= csum ^ bus.rx_data;
      if (xfer && (state == LEN_HI)) len[CNT_W-1:BYTE_W] <= bus.rx_data;
      if (xfer && (state == LEN_LO)) len[BYTE_W-1:0]     <= bus.rx_data;
      if (last_byte_c) begin
        imem_addr <= word_addr(BASE_ADDR, word_idx);
        word_idx  <= word_idx + CNT_W'(1);
      end
    end
  end

  // The write strobe and data come straight from the assembler's registers.
  assign bus.imem_we    = word_done;
  assign bus.imem_wdata = word;
  assign bus.imem_addr  = imem_addr;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a stream-level reference model.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int unsigned NW     = 512;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          BUDGET = 20000;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, cpu_reset, busy, done, err;
  prog_loader_if bus();

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] obs_wa[$], obs_wd[$], exp_wa[$], exp_wd[$];
  logic exp_ok;
  int   exp_used, used;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every instruction-memory write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_wa.push_back(bus.imem_addr);
      obs_wd.push_back(bus.imem_wdata);
    end
  end

  // Reference: expected writes, outcome and number of bytes the loader takes.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_wa.delete();
    exp_wd.delete();
    n = 32'({s[0], s[1]});
    x = s[0] ^ s[1];
    if (n > NW) begin
      exp_ok   = 1'b0;
      exp_used = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
      x = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
      exp_wa.push_back(BASE + 32'(4*k));
      exp_wd.push_back(w);
    end
    exp_ok   = (s[2+4*n] == x);
    exp_used = 3 + 4*n;
  endtask

  function automatic bq_t build(input int n, input logic [7:0] flip);
    bq_t q;
    logic [7:0] x, b;
    logic [15:0] c;
    c = 16'(n);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
    x = c[15:8] ^ c[7:0];
    for (int i = 0; i < ((n > NW) ? 8 : 4*n); i++) begin
      b = 8'($urandom);
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(x ^ flip);
    return q;
  endfunction

  task automatic run_load(input bq_t s, input bit throttle, input bit mid_start, input int max_bytes);
    int idx = 0;
    int cyc = 0;
    bit v;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (idx < s.size() && idx < max_bytes && cyc < BUDGET) begin
      if (bus.rx_ready !== 1'b1) break;
      v = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.rx_valid = v;
      bus.rx_data  = v ? s[idx] : 8'($urandom);
      start        = mid_start && (idx == 3);
      @(negedge clk);
      cyc++;
      if (v) idx++;
    end
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    used         = idx;
    check("cycle_budget", 64'(cyc < BUDGET), 64'(1));
  endtask

  task automatic load_and_check(input string tag, input bq_t s, input bit throttle, input bit mid_start);
    int m;
    obs_wa.delete();
    obs_wd.delete();
    model(s);
    run_load(s, throttle, mid_start, 1 << 30);
    @(negedge clk);
    check({tag, ".used"},    64'(used),          64'(exp_used));
    check({tag, ".nwrites"}, 64'(obs_wa.size()), 64'(exp_wa.size()));
    m = (obs_wa.size() < exp_wa.size()) ? obs_wa.size() : exp_wa.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(obs_wa[i]), 64'(exp_wa[i]));
      check($sformatf("%s.data%0d", tag, i), 64'(obs_wd[i]), 64'(exp_wd[i]));
    end
    check({tag, ".done"},      64'(done),         64'(exp_ok));
    check({tag, ".err"},       64'(err),          64'(!exp_ok));
    check({tag, ".cpu_reset"}, 64'(cpu_reset),    64'(!exp_ok));
    check({tag, ".busy"},      64'(busy),         64'(0));
    check({tag, ".rx_ready"},  64'(bus.rx_ready), 64'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      64'(busy),           64'(0));
    check({tag, ".done"},      64'(done),           64'(0));
    check({tag, ".err"},       64'(err),            64'(0));
    check({tag, ".cpu_reset"}, 64'(cpu_reset),      64'(1));
    check({tag, ".rx_ready"},  64'(bus.rx_ready),   64'(0));
    check({tag, ".we"},        64'(bus.imem_we),    64'(0));
    check({tag, ".addr"},      64'(bus.imem_addr),  64'(0));
    check({tag, ".wdata"},     64'(bus.imem_wdata), 64'(0));
  endtask

  logic [7:0] demo_a [11] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                              8'h01, 8'h23, 8'h45, 8'h67, 8'h20};

  initial begin
    bq_t demo, q;
    int n;
    logic [7:0] flip;

    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Two-word load; the XOR of these ten bytes is 8'h20.
    foreach (demo_a[i]) demo.push_back(demo_a[i]);
    load_and_check("two_words", demo, 1'b0, 1'b0);

    q = demo; q[10] = 8'h31;
    load_and_check("bad_csum31", q, 1'b0, 1'b0);
    q[10] = 8'h30;
    load_and_check("bad_csum30", q, 1'b0, 1'b0);

    q.delete();
    q.push_back(8'h02); q.push_back(8'h01);
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    load_and_check("oversize", q, 1'b0, 1'b0);

    q.delete();
    q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    load_and_check("zero_ok", q, 1'b0, 1'b0);
    q[2] = 8'h05;
    load_and_check("zero_bad", q, 1'b0, 1'b0);

    load_and_check("throttled", demo, 1'b1, 1'b1);

    // Reset arrives together with the sixth byte and a start request.
    obs_wa.delete();
    obs_wd.delete();
    run_load(demo, 1'b0, 1'b0, 5);
    bus.rx_valid = 1'b1;
    bus.rx_data  = demo[5];
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    check("midreset.nwrites", 64'(obs_wa.size()), 64'(0));
    check_idle("midreset");
    @(negedge clk);
    check_idle("midreset2");
    load_and_check("reload", demo, 1'b0, 1'b0);

    load_and_check("max_words", build(NW, 8'h00), 1'b1, 1'b0);
    load_and_check("max_plus1", build(NW + 1, 8'h00), 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      n    = (t == 11) ? int'($urandom_range(513, 65535)) : int'($urandom_range(0, 6));
      flip = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      load_and_check($sformatf("rand%0d", t), build(n, flip),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
